mul_div_unit: RTL

//  Parametrised multiply/divide unit with HI/LO registers; the EX-stage companion of the ALU.

---
 rtl/mdu_pkg.sv | 34 +++
 rtl/mdu_if.sv | 15 +
 rtl/mdu_div_core.sv | 62 ++++++
 rtl/mul_div_unit.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - op codes, FSM states and sign helpers for the multiply/divide unit
package mdu_pkg;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MADD  = 4'd6;
    localparam logic [3:0] OP_MADDU = 4'd7;
    localparam logic [3:0] OP_MSUB  = 4'd8;
    localparam logic [3:0] OP_MSUBU = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    // Helpers work on a wide container; callers cast in and out at their own WIDTH.
    localparam int MAX_W = 64;

    function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] x, input int w,
                                                 input logic is_signed);
        return cond_neg(x, is_signed && x[w-1]);
    endfunction

endpackage

// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - request/result bundle between the EX stage and the multiply/divide unit
interface mdu_if #(parameter int WIDTH = 32);
    logic             start;
    logic [3:0]       md_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, md_op, a, b, flush, input busy, done, hi, lo);
    modport slave  (input start, md_op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_div_core.sv
// rtl/mdu_div_core.sv - iterative restoring divider on unsigned magnitudes, one bit per cycle
module mdu_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             valid
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CNT_W-1:0] cnt;
    logic             active;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // quot_q doubles as the dividend shift register; its MSB feeds the partial remainder.
    assign shifted = {rem_q, quot_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quot_q <= '0;
            dvs_q  <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (abort) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (load) begin
            rem_q  <= '0;
            quot_q <= dividend;
            dvs_q  <= divisor;
            cnt    <= CNT_W'(WIDTH);
            active <= 1'b1;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
            if (!diff[WIDTH]) begin
                rem_q  <= diff[WIDTH-1:0];
                quot_q <= {quot_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_q  <= shifted[WIDTH-1:0];
                quot_q <= {quot_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign quot  = quot_q;
    assign rem   = rem_q;
    assign valid = active && (cnt == '0);

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multi-cycle MULT/DIV unit with HI/LO; MDU_MADD_EN adds MADD/MSUB accumulate ops
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic  clk,
    input  logic  rst_n,
    mdu_if.slave  bus
);

    localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_q, b_q, hi_q, lo_q;
    logic [3:0]         op_q;
    logic               quot_neg, rem_neg, div_zero, done_q;
    logic               accept, is_mul, is_div, div_signed;
    logic               mul_commit, fix_exit, div_commit, div_load, div_valid;
    logic               mul_signed;
    logic [WIDTH-1:0]   dvd_mag, dvs_mag, quot_mag, rem_mag, quot_fix, rem_fix;
    logic [2*WIDTH-1:0] ext_a, ext_b, product, mul_result;

    assign bus.busy = (state != ST_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    assign accept = bus.start && !bus.busy && !bus.flush;

    always_comb begin
        is_mul = (bus.md_op == OP_MULT) || (bus.md_op == OP_MULTU);
`ifdef MDU_MADD_EN
        is_mul = is_mul || (bus.md_op == OP_MADD) || (bus.md_op == OP_MADDU)
                        || (bus.md_op == OP_MSUB) || (bus.md_op == OP_MSUBU);
`endif
        is_div     = (bus.md_op == OP_DIV) || (bus.md_op == OP_DIVU);
        div_signed = (bus.md_op == OP_DIV);
    end

    always_comb begin
        state_nxt  = state;
        mul_commit = 1'b0;
        fix_exit   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept && is_mul)
                    state_nxt = ST_MUL;
                else if (accept && is_div)
                    state_nxt = (bus.b == '0) ? ST_FIX : ST_DIV;
            end
            ST_MUL: begin
                if (bus.flush) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == '0) begin
                    state_nxt  = ST_IDLE;
                    mul_commit = 1'b1;
                end
            end
            ST_DIV: begin
                if (bus.flush)
                    state_nxt = ST_IDLE;
                else if (cnt == '0)
                    state_nxt = ST_FIX;
            end
            ST_FIX: begin
                if (bus.flush) begin
                    state_nxt = ST_IDLE;
                end else if (div_zero || div_valid) begin
                    state_nxt = ST_IDLE;
                    fix_exit  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Divide by zero skips the core entirely and only spends the FIX cycle.
    assign div_commit = fix_exit && !div_zero;
    assign div_load   = accept && is_div && (bus.b != '0);
    assign dvd_mag    = WIDTH'(abs_val(MAX_W'(bus.a), WIDTH, div_signed));
    assign dvs_mag    = WIDTH'(abs_val(MAX_W'(bus.b), WIDTH, div_signed));
    assign quot_fix   = WIDTH'(cond_neg(MAX_W'(quot_mag), quot_neg));
    assign rem_fix    = WIDTH'(cond_neg(MAX_W'(rem_mag), rem_neg));

    mdu_div_core #(.WIDTH(WIDTH)) u_div_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (div_load),
        .abort    (bus.flush),
        .dividend (dvd_mag),
        .divisor  (dvs_mag),
        .quot     (quot_mag),
        .rem      (rem_mag),
        .valid    (div_valid)
    );

    // One 2W x 2W multiply covers both signednesses once the operands are extended.
    always_comb begin
        mul_signed = (op_q == OP_MULT);
`ifdef MDU_MADD_EN
        mul_signed = mul_signed || (op_q == OP_MADD) || (op_q == OP_MSUB);
`endif
        ext_a      = mul_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        ext_b      = mul_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        product    = ext_a * ext_b;
        mul_result = product;
`ifdef MDU_MADD_EN
        if ((op_q == OP_MADD) || (op_q == OP_MADDU))
            mul_result = {hi_q, lo_q} + product;
        else if ((op_q == OP_MSUB) || (op_q == OP_MSUBU))
            mul_result = {hi_q, lo_q} - product;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt      <= '0;
            quot_neg <= 1'b0;
            rem_neg  <= 1'b0;
            div_zero <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= mul_commit || fix_exit;
            if (accept) begin
                a_q      <= bus.a;
                b_q      <= bus.b;
                op_q     <= bus.md_op;
                quot_neg <= div_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                rem_neg  <= div_signed && bus.a[WIDTH-1];
                div_zero <= (bus.b == '0);
                cnt      <= is_div ? CNT_W'(WIDTH - 1) : CNT_W'(MUL_LAT - 1);
            end else if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (accept && (bus.md_op == OP_MTHI)) hi_q <= bus.a;
            if (accept && (bus.md_op == OP_MTLO)) lo_q <= bus.a;
            if (mul_commit) {hi_q, lo_q} <= mul_result;
            if (div_commit) begin
                lo_q <= quot_fix;
                hi_q <= rem_fix;
            end
        end
    end

endmodule
